// File: rtl/led_pkg.sv
// led_pkg: shared mode and bounce-direction encodings for the LED pattern generator
// Exports: mode_e (MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_BLINK), dir_e (LEFT, RIGHT)
package led_pkg;
    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..TICKS-1 counter that flags its terminal count
// Ports: clk, rst_n (sync, active-low), enable (count/hold), clear (restart at 0),
//        terminal (combinational: count == TICKS-1 && enable)
module tick_prescaler #(
    parameter int TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic terminal
);
    if (TICKS < 1) begin : g_bad_ticks
        $error("tick_prescaler: TICKS must be >= 1");
    end
    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        terminal = enable && (cnt_q == CW'(TICKS - 1));
        cnt_d    = clear ? '0 : terminal ? '0 : enable ? cnt_q + CW'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern engine (count up/down, bounce, blink) with pause and single-step
// Ports: clk, rst_n (sync, active-low), mode[1:0] (pattern select), enable (free-run),
//        step (rising edge advances once while paused), leds[WIDTH-1:0] (registered pattern),
//        tick (high in the cycle leds shows a newly advanced value)
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 2,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             enable,
    input  logic             step,
    output logic [WIDTH-1:0] leds,
    output logic             tick
);
    localparam int TICK_CYCLES = CLK_FREQ / TICK_HZ;
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic             step_q;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             tick_q, tick_d;
    logic             terminal, mode_chg, advance, at_end;
    assign mode_chg = mode != mode_q;
    assign advance  = terminal || (step && !step_q && !enable);
    assign leds     = leds_q;
    assign tick     = tick_q;
    tick_prescaler #(.TICKS(TICK_CYCLES)) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .clear   (mode_chg),
        .terminal(terminal)
    );
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        leds_d = leds_q;
        tick_d = advance && !mode_chg;
        // bounce reverses when the lit bit already sits at the edge it is moving towards
        at_end = (dir_q == LEFT) ? leds_q[WIDTH-1] : leds_q[0];
        if (mode_chg) begin
            mode_d = mode_e'(mode);
            dir_d  = LEFT;
            leds_d = (mode == MODE_DOWN) ? '1 : (mode == MODE_BOUNCE) ? WIDTH'(1) : '0;
        end else if (advance) begin
            case (mode_q)
                MODE_UP:   leds_d = leds_q + WIDTH'(1);
                MODE_DOWN: leds_d = leds_q - WIDTH'(1);
                MODE_BOUNCE: begin
                    dir_d  = at_end ? dir_e'(~dir_q) : dir_q;
                    leds_d = (WIDTH == 1) ? leds_q : (dir_d == LEFT) ? leds_q << 1 : leds_q >> 1;
                end
                default:   leds_d = ~leds_q;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_UP;
            dir_q  <= LEFT;
            step_q <= 1'b0;
            leds_q <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            step_q <= step;
            leds_q <= leds_d;
            tick_q <= tick_d;
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen (CLK_FREQ=20, TICK_HZ=2, WIDTH=4)
module tb_led_pattern_gen;
    typedef struct packed {
        logic [3:0] leds;
        logic       tick;
    } obs_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       enable = 1'b0;
    logic       step = 1'b0;
    logic [3:0] leds;
    logic       tick;
    int         n_checks = 0;
    int         n_fail = 0;
    obs_t       sb[$];
    int         m_mode, m_cnt, m_pos, m_dir;
    logic [3:0] m_leds;
    logic       m_tick, m_step_prev;
    led_pattern_gen #(.CLK_FREQ(20), .TICK_HZ(2), .WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .enable(enable),
        .step  (step),
        .leds  (leds),
        .tick  (tick)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // reference model: bounce tracked as a lit position rather than a shifted vector
    task automatic model_edge();
        logic adv;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_pos = 0; m_dir = 0;
            m_leds = 4'd0; m_tick = 1'b0; m_step_prev = 1'b0;
            return;
        end
        adv = (enable && m_cnt == 9) || (step && !m_step_prev && !enable);
        m_step_prev = step;
        if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_cnt = 0; m_tick = 1'b0; m_dir = 0; m_pos = 0;
            m_leds = (m_mode == 1) ? 4'hf : (m_mode == 2) ? 4'h1 : 4'h0;
            return;
        end
        if (enable) m_cnt = (m_cnt == 9) ? 0 : m_cnt + 1;
        m_tick = adv;
        if (!adv) return;
        case (m_mode)
            0: m_leds = m_leds + 4'd1;
            1: m_leds = m_leds - 4'd1;
            2: begin
                if (m_dir == 0) begin
                    if (m_pos == 3) begin m_dir = 1; m_pos = 2; end else m_pos++;
                end else begin
                    if (m_pos == 0) begin m_dir = 0; m_pos = 1; end else m_pos--;
                end
                m_leds = 4'(1 << m_pos);
            end
            default: m_leds = ~m_leds;
        endcase
    endtask
    task automatic cyc(input logic r, input logic [1:0] m, input logic e, input logic s);
        obs_t o;
        @(negedge clk);
        rst_n = r; mode = m; enable = e; step = s;
        model_edge();
        sb.push_back('{leds: m_leds, tick: m_tick});
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("leds", 32'(leds), 32'(o.leds));
        check("tick", 32'(tick), 32'(o.tick));
    endtask
    initial begin
        int ticks, base, lat;
        // 1: count up with wrap
        cyc(0, 0, 1, 0);
        check("reset_leds", 32'(leds), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        for (int i = 0; i < 165; i++) cyc(1, 0, 1, 0);
        check("up_wrap", 32'(leds), 32'd0);
        // 2: count down from reset
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        check("down_init", 32'(leds), 32'd15);
        for (int i = 0; i < 170; i++) cyc(1, 1, 1, 0);
        // 3: bounce
        cyc(0, 2, 1, 0);
        for (int i = 0; i < 80; i++) cyc(1, 2, 1, 0);
        // 4: paused single-step, then steps ignored while running
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        base = leds;
        ticks = 0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin cyc(1, 0, 0, 1); ticks += tick; end
            for (int i = 0; i < 3; i++) begin cyc(1, 0, 0, 0); ticks += tick; end
        end
        check("step_ticks", 32'(ticks), 32'd2);
        check("step_leds", 32'(leds), 32'(base + 2));
        for (int i = 0; i < 30; i++) cyc(1, 0, 1, (i % 4) < 2);
        // 5: mode change coinciding with terminal count
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 12 && m_cnt != 9; i++) cyc(1, 0, 1, 0);
        check("presc_at_terminal", 32'(m_cnt), 32'd9);
        cyc(1, 3, 1, 0);
        check("chg_leds", 32'(leds), 32'd0);
        check("chg_tick", 32'(tick), 32'd0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cyc(1, 3, 1, 0);
            if (leds == 4'hf) lat = i;
        end
        check("blink_latency", 32'(lat), 32'd10);
        // 6: reset mid-bounce while moving right
        cyc(0, 2, 1, 0);
        for (int i = 0; i < 100 && !(m_mode == 2 && m_dir == 1); i++) cyc(1, 2, 1, 0);
        check("dir_right", 32'(m_dir), 32'd1);
        cyc(0, 2, 1, 0);
        check("rst_mid_leds", 32'(leds), 32'd0);
        check("rst_mid_tick", 32'(tick), 32'd0);
        cyc(1, 2, 1, 0);
        check("rst_bounce_init", 32'(leds), 32'd1);
        for (int i = 0; i < 10; i++) cyc(1, 2, 1, 0);
        check("rst_bounce_next", 32'(leds), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
